// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - primary/secondary write request bundle for the regfile write arbiter
interface rf_write_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          p_we;
  logic [AW-1:0] p_wa;
  logic [DW-1:0] p_wd;
  logic          p_hold;
  logic          s_valid;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd;
  logic          s_ready;

  modport master (
    output p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
    input  p_hold, s_ready
  );

  modport slave (
    input  p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
    output p_hold, s_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the regfile write port between WB and a queued long-latency unit
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 32,
  parameter int AW           = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  rf_write_arbiter_if.slave        bus,
  input  logic [AW-1:0]            chk_ra1,
  input  logic [AW-1:0]            chk_ra2,
  output logic                     hazard,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] mem_wa [DEPTH];
  logic [DW-1:0] mem_wd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve, starve_next;
  logic          hold;
  logic          p_req, ready, push, grant_p, pop;

  assign p_req   = bus.p_we && (bus.p_wa != '0);
  assign ready   = (count < CW'(DEPTH));
  // Writes to register 0 complete the handshake but are dropped here.
  assign push    = bus.s_valid && ready && (bus.s_wa != '0);
  assign grant_p = !hold && p_req;
  assign pop     = !grant_p && (count != '0);

  assign bus.s_ready = ready;
  assign bus.p_hold  = hold;
  assign fifo_count  = count;

  always_comb begin
    starve_next = starve;
    if (pop)
      starve_next = '0;
    else if (grant_p && (count != '0) && (starve != SW'(STARVE_LIMIT)))
      starve_next = starve + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
      hold   <= 1'b0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else begin
      starve <= starve_next;
      // Hold lasts one cycle: the forced pop in that cycle clears the counter.
      hold   <= (starve_next == SW'(STARVE_LIMIT));
      count  <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (grant_p) begin
        rf_we <= 1'b1;
        rf_wa <= bus.p_wa;
        rf_wd <= bus.p_wd;
      end else if (pop) begin
        rf_we <= 1'b1;
        rf_wa <= mem_wa[rd_ptr];
        rf_wd <= mem_wd[rd_ptr];
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= bus.s_wa;
      mem_wd[wr_ptr] <= bus.s_wd;
    end
  end

  always_comb begin
    logic [PW-1:0] offset;
    hazard = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ({1'b0, offset} < count) begin
        if ((chk_ra1 != '0) && (chk_ra1 == mem_wa[i])) hazard = 1'b1;
        if ((chk_ra2 != '0) && (chk_ra2 == mem_wa[i])) hazard = 1'b1;
      end
    end
    if (rf_we) begin
      if ((chk_ra1 != '0) && (chk_ra1 == rf_wa)) hazard = 1'b1;
      if ((chk_ra2 != '0) && (chk_ra2 == rf_wa)) hazard = 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - vector table, corner sequences and randomized model check for rf_write_arbiter
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  chk_ra1, chk_ra2;
  logic        hazard, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_count;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.AW(5), .DW(32)) bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard(hazard),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .fifo_count(fifo_count)
  );

  int nchk = 0;
  int nfail = 0;

  typedef struct packed { logic [4:0] wa; logic [31:0] wd; } ent_t;
  ent_t        q[$];
  int          m_starve;
  logic        m_hold, m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  typedef struct {
    logic p_we; logic [4:0] p_wa; logic [31:0] p_wd;
    logic s_valid; logic [4:0] s_wa; logic [31:0] s_wd;
    logic [4:0] ra1; logic [4:0] ra2;
    logic x_ready; logic x_hazard; logic x_we; logic [4:0] x_wa; logic [31:0] x_wd; int x_cnt;
  } vec_t;
  vec_t vecs[15];

  function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd, logic sv, logic [4:0] sa,
                              logic [31:0] sd, logic [4:0] r1, logic [4:0] r2, logic xr, logic xh,
                              logic xw, logic [4:0] xa, logic [31:0] xd, int xc);
    vec_t v;
    v.p_we = pw; v.p_wa = pa; v.p_wd = pd; v.s_valid = sv; v.s_wa = sa; v.s_wd = sd;
    v.ra1 = r1; v.ra2 = r2; v.x_ready = xr; v.x_hazard = xh; v.x_we = xw; v.x_wa = xa;
    v.x_wd = xd; v.x_cnt = xc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve = 0; m_hold = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic m_hazard();
    logic h = 1'b0;
    foreach (q[i]) begin
      if (chk_ra1 != 0 && chk_ra1 == q[i].wa) h = 1'b1;
      if (chk_ra2 != 0 && chk_ra2 == q[i].wa) h = 1'b1;
    end
    if (m_we && chk_ra1 != 0 && chk_ra1 == m_wa) h = 1'b1;
    if (m_we && chk_ra2 != 0 && chk_ra2 == m_wa) h = 1'b1;
    return h;
  endfunction

  // One arbitration cycle of the reference, from the inputs that were present at the edge.
  task automatic model_step();
    logic preq, rdy, push;
    ent_t e;
    preq = bus.p_we && bus.p_wa != 0;
    rdy  = q.size() < DEPTH;
    push = bus.s_valid && rdy && bus.s_wa != 0;
    if (!m_hold && preq) begin
      m_we = 1'b1; m_wa = bus.p_wa; m_wd = bus.p_wd;
      if (q.size() > 0 && m_starve < LIMIT) m_starve++;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_wa = e.wa; m_wd = e.wd; m_starve = 0;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.wa = bus.s_wa; e.wd = bus.s_wd;
      q.push_back(e);
    end
    m_hold = (m_starve == LIMIT);
  endtask

  task automatic drive(logic pw, logic [4:0] pa, logic [31:0] pd, logic sv, logic [4:0] sa,
                       logic [31:0] sd, logic [4:0] r1, logic [4:0] r2);
    bus.p_we = pw; bus.p_wa = pa; bus.p_wd = pd;
    bus.s_valid = sv; bus.s_wa = sa; bus.s_wd = sd;
    chk_ra1 = r1; chk_ra2 = r2;
  endtask

  task automatic pre_check();
    #1;
    check("s_ready", bus.s_ready, q.size() < DEPTH);
    check("hazard", hazard, m_hazard());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("rf_we", rf_we, m_we);
    if (m_we) begin
      check("rf_wa", rf_wa, m_wa);
      check("rf_wd", rf_wd, m_wd);
    end
    check("fifo_count", fifo_count, q.size());
    check("p_hold", bus.p_hold, m_hold);
    check("we_r0", rf_we && rf_wa == 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_wa", rf_wa, 0);
    check("reset_rf_wd", rf_wd, 0);
    check("reset_p_hold", bus.p_hold, 0);
    check("reset_count", fifo_count, 0);
    check("reset_s_ready", bus.s_ready, 1);
    #10 rst = 1'b0;

    vecs[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0,     0, 0, 1, 0, 1, 7, 32'hDEADBEEF, 0);
    vecs[1]  = mk(1, 0, 32'h5,        0, 0, 0,     7, 0, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,            1, 3, 32'h11, 7, 0, 1, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0,     3, 0, 1, 1, 1, 3, 32'h11, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 8, 32'h88,       1, 9, 32'h99, 9, 0, 1, 0, 1, 8, 32'h88, 1);
    vecs[6]  = mk(0, 0, 0,            1, 0, 32'h1,  9, 0, 1, 1, 1, 9, 32'h99, 0);
    vecs[7]  = mk(0, 0, 0,            0, 0, 0,     9, 0, 1, 1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,            0, 0, 0,     9, 0, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 32'hA1,       1, 4, 32'h44, 0, 0, 1, 0, 1, 1, 32'hA1, 1);
    vecs[10] = mk(1, 2, 32'hA2,       1, 5, 32'h55, 0, 0, 1, 0, 1, 2, 32'hA2, 2);
    vecs[11] = mk(1, 1, 32'hA3,       1, 6, 32'h66, 0, 0, 0, 0, 1, 1, 32'hA3, 2);
    vecs[12] = mk(0, 0, 0,            0, 0, 0,     5, 0, 0, 1, 1, 4, 32'h44, 1);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 1, 5, 32'h55, 0);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].p_we, vecs[i].p_wa, vecs[i].p_wd, vecs[i].s_valid, vecs[i].s_wa,
            vecs[i].s_wd, vecs[i].ra1, vecs[i].ra2);
      pre_check();
      check($sformatf("vec%0d_s_ready", i), bus.s_ready, vecs[i].x_ready);
      check($sformatf("vec%0d_hazard", i), hazard, vecs[i].x_hazard);
      tick();
      check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].x_we);
      if (vecs[i].x_we) begin
        check($sformatf("vec%0d_rf_wa", i), rf_wa, vecs[i].x_wa);
        check($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].x_wd);
      end
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].x_cnt);
    end

    // Starvation: queued entry loses four times, then is forced; counter restarts afterwards.
    for (int round = 0; round < 2; round++) begin
      drive(1, 11, 32'h1111, 1, 10 + round, 32'h1010 + round, 0, 0);
      pre_check();
      tick();
      check("starve_enq_count", fifo_count, 1);
      for (int k = 1; k <= 4; k++) begin
        drive(1, 12, 32'h1212, 0, 0, 0, 0, 0);
        pre_check();
        tick();
        check($sformatf("starve_r%0d_hold%0d", round, k), bus.p_hold, k == 4);
      end
      drive(1, 13, 32'h1313, 0, 0, 0, 0, 0);
      pre_check();
      tick();
      check("starve_forced_we", rf_we, 1);
      check("starve_forced_wa", rf_wa, 10 + round);
      check("starve_forced_wd", rf_wd, 32'h1010 + round);
      check("starve_hold_drop", bus.p_hold, 0);
      drive(1, 14, 32'h1414, 0, 0, 0, 0, 0);
      pre_check();
      tick();
      check("starve_replay_wa", rf_wa, 14);
    end

    // Asynchronous reset with two entries queued.
    drive(1, 7, 32'h7, 1, 20, 32'h20, 0, 0);
    pre_check();
    tick();
    drive(1, 7, 32'h7, 1, 21, 32'h21, 0, 0);
    pre_check();
    tick();
    check("rst_pre_count", fifo_count, 2);
    drive(1, 7, 32'h7, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_count", fifo_count, 0);
    check("rst_async_we", rf_we, 0);
    check("rst_async_hold", bus.p_hold, 0);
    check("rst_async_ready", bus.s_ready, 1);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_after_we", rf_we, 0);
    end

    // Randomized traffic against the queue model; small address range keeps hazards and r0 frequent.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      pre_check();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- Primary: pipeline writeback (WB stage), one write per cycle, normally wins.
- Secondary: long-latency unit (mult/div, later load-miss return), accepted through a valid/ready handshake into a small FIFO.
- Drives the regfile's we/wa/wd from registered outputs, raises a pipeline hold on starvation, and flags read hazards against queued writes.

Parameters:
- DEPTH, 2, secondary FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before it is forced.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- p_we  in  1  primary write request.
- p_wa  in  AW  primary destination register.
- p_wd  in  DW  primary write data.
- p_hold  out  1  primary must freeze; a primary request presented while high is not taken.
- s_valid  in  1  secondary request valid.
- s_wa  in  AW  secondary destination register.
- s_wd  in  DW  secondary write data.
- s_ready  out  1  secondary FIFO can accept.
- chk_ra1  in  AW  decode-stage source register 1.
- chk_ra2  in  AW  decode-stage source register 2.
- hazard  out  1  a source register has a pending queued or output-stage write.
- rf_we  out  1  regfile write enable (registered).
- rf_wa  out  AW  regfile write address (registered).
- rf_wd  out  DW  regfile write data (registered).
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_wa=0, rf_wd=0, p_hold=0.
  - FIFO emptied (fifo_count=0), starve counter=0.
  - Reset mid-operation discards queued writes; no partial write issues.
- Register 0:
  - A primary request with p_wa=0 is treated as no request.
  - A secondary handshake with s_wa=0 completes but is not enqueued.
  - rf_we never asserts with rf_wa=0.
- Secondary handshake:
  - Transfer when s_valid & s_ready; entry is pushed at posedge.
  - s_ready = (fifo_count < DEPTH), combinational from registered count.
  - No full-bypass: s_ready stays low when full, even if a pop happens the same cycle.
- Arbitration each cycle (result registered into rf_* at posedge, latency 1):
  - If p_hold=0 and primary request: grant primary; if FIFO nonempty, starve counter +1.
  - Else if FIFO nonempty: grant FIFO head, pop, starve counter cleared.
  - Else: rf_we=0 next cycle.
- Secondary latency: handshake to rf_we is minimum 2 cycles (enqueue, then issue).
- Starvation:
  - When the starve counter reaches STARVE_LIMIT, p_hold registers high for exactly one cycle.
  - In that cycle the FIFO head is granted unconditionally and the counter clears.
  - The primary request in that cycle is ignored; the pipeline re-presents it next cycle.
- Simultaneous push and pop while not full: both occur; count unchanged.
- Push into empty FIFO and pop in the same cycle: not possible, since the new entry is visible only after the edge.
- Ordering:
  - FIFO entries issue in arrival order.
  - No merging of writes to the same register.
  - Two queued writes to the same register both issue, oldest first.
- Hazard (combinational):
  - hazard=1 if a nonzero chk_ra1 or chk_ra2 equals the wa of any valid FIFO entry, or equals rf_wa while rf_we=1.
  - Register 0 never hazards.
- Counters:
  - Starve counter saturates at STARVE_LIMIT.
  - fifo_count never exceeds DEPTH or underflows.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Reset -> all outputs 0, s_ready=1, fifo_count=0. Assert rst mid-stream with 2 entries queued -> fifo_count=0 immediately, no rf_we after release.
- Primary only: p_we=1, p_wa=7, p_wd=32'hDEADBEEF -> next cycle rf_we=1, rf_wa=7, rf_wd=32'hDEADBEEF. p_wa=0 -> rf_we stays 0.
- Secondary only: one handshake, s_wa=3, s_wd=32'h11 -> fifo_count=1 next cycle, then rf_we=1, rf_wa=3, rf_wd=32'h11; two cycles after handshake, fifo_count=0.
- Fill and order: push wa=4 then wa=5 with p_we held high -> s_ready=0 at count 2. Drop p_we -> writes issue as 4 then 5.
- Starvation: p_we=1 continuously with one queued entry -> after 4 cycles p_hold=1 for one cycle, FIFO entry written, primary held; counter then restarts.
- Hazard: queue wa=9, chk_ra1=9 -> hazard=1; chk_ra2=0 with a queued wa=0 handshake -> hazard=0. After the entry issues and rf_we drops -> hazard=0.
